pc_stack: RTL and testbench
===========================

# pc_stack

Parametrised program counter with a built-in return-address stack, the next-generation sequencer for the CPU datapath. It keeps the load/increment/reset behaviour of the 16-bit program counter, and adds a configurable width and increment step. It also adds hardware call/return with a `DEPTH`-entry LIFO and sticky overflow/underflow error flags. It sits between the control decoder and the instruction-memory address port.

## Interface

- `WIDTH`, 16, counter and address width in bits
- `DEPTH`, 8, return-stack entries (≥1)
- `STEP`, 1, increment amount added on `inc`/`call`
- `RESET_VEC`, 0, value of `out` after `rst_n` or `clr`

- `clk`  in  1  single clock; all state updates on posedge
- `rst_n`  in  1  reset, asynchronous, active-low
- `clr`  in  1  synchronous architectural reset (replaces old `reset` input)
- `load`  in  1  jump: `out <= in`
- `call`  in  1  push return address, then jump to `in`
- `ret`  in  1  pop top of stack into `out`
- `inc`  in  1  `out <= out + STEP`
- `in`  in  WIDTH  jump/call target
- `out`  out  WIDTH  current PC, registered
- `top`  out  WIDTH  current top-of-stack, 0 when empty
- `depth`  out  $clog2(DEPTH+1)  valid stack entries
- `empty`  out  1  `depth == 0`
- `full`  out  1  `depth == DEPTH`
- `overflow`  out  1  sticky: `call` attempted while full
- `underflow`  out  1  sticky: `ret` attempted while empty

## Operation

- One operation per cycle, strict priority: `clr` > `load` > `call` > `ret` > `inc` > hold.
- Lower-priority strobes asserted in the same cycle are ignored entirely, with no side effects on the stack or flags.
- `clr`: `out <= RESET_VEC`, stack emptied (`depth <= 0`), `overflow`/`underflow` cleared.
- `load`: `out <= in`; stack and flags untouched.
- `call`, not full: push `out + STEP` and set `out <= in`.
- `call`, full: jump still taken (`out <= in`), push discarded, stack contents unchanged, `overflow <= 1`.
- `ret`, not empty: `out <= top`, pop one entry.
- `ret`, empty: `out` holds, `underflow <= 1`.
- `inc`: `out <= out + STEP`.
- Arithmetic is modulo 2^WIDTH: `out = 2^WIDTH-1` with `STEP=1` wraps to 0. The pushed return address wraps identically.
- Sticky flags clear only on `rst_n` or `clr`.
- Stack storage is not reset. Only the pointer is reset; entries at or above `depth` are don't-care.

## Timing

- All outputs are registered or decoded from registers; no combinational path from any input to any output.
- Latency 1: an operation strobed in cycle N is visible on `out`, `top`, `depth` and the flags after posedge N+1.
- `ret` in the cycle after `call` returns the address pushed by that `call`. Back-to-back `call`/`ret` at full rate is supported.
- `rst_n` low asynchronously forces `out=RESET_VEC`, `depth=0`, `empty=1`, `full=0`, `top=0`, `overflow=0`, `underflow=0`.
- Reset mid-operation aborts any strobe in flight.
- Deassertion of `rst_n` is synchronised externally; the first active edge after release performs a normal operation.

## Structure

- Package `pc_pkg` contains:
  - `pc_op_e` enum (`PC_HOLD`, `PC_INC`, `PC_RET`, `PC_CALL`, `PC_LOAD`, `PC_CLR`);
  - a `pc_decode` function mapping the strobes to `pc_op_e` with the priority above.
- Sub-module `lifo_stack` (params `WIDTH`, `DEPTH`) handles storage:
  - ports `push`, `pop`, `wdata`, `rdata`, `depth`, `full`, `empty`;
  - it ignores `push` when full and `pop` when empty.
- `pc_stack` owns `out`, the step adder and the sticky flags.

## Test plan

- `rst_n` pulse, then `inc` ×3 with `STEP=1`, `RESET_VEC=0` -> `out` = 1, 2, 3; `depth=0`, flags 0.
- `out=0x0010`, `call` with `in=0x0200`, then `inc`, then `ret` -> `out` = 0x0200, 0x0201, 0x0011; `depth` 1 then 0.
- `DEPTH=2`: three `call`s to 0x100, 0x200, 0x300 starting at `out=0x5` -> `out=0x300`, `full=1`, `overflow=1`, `top=0x101`. Two `ret`s -> `out` = 0x101, then 0x6.
- `ret` when empty with `out=0x40` -> `out` stays 0x40, `underflow=1`. A following `inc` -> `out=0x41`, `underflow` still 1. `clr` -> `out=0`, both flags 0.
- `load`+`call`+`inc` together with `in=0x123` -> `out=0x123`, `depth` unchanged. `clr`+`load` together -> `out=RESET_VEC`.
- `WIDTH=8`, `STEP=2`, `out=0xFF`, `call` to 0x10, then `ret` -> return address 0x01, `out=0x01`. Assert `rst_n` asynchronously mid-cycle -> all outputs at reset values before the next edge.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types for the program-counter sequencer.
//   pc_op_e   : the single operation performed in a cycle
//   pc_decode : maps the raw strobes to one operation, highest priority first
package pc_pkg;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INC,
        PC_RET,
        PC_CALL,
        PC_LOAD,
        PC_CLR
    } pc_op_e;

    // Priority: clr > load > call > ret > inc > hold. Anything below the
    // winning strobe is dropped, so it can never touch the stack or flags.
    function automatic pc_op_e pc_decode(
        input logic clr,
        input logic load,
        input logic call,
        input logic ret,
        input logic inc
    );
        if (clr) begin
            return PC_CLR;
        end else if (load) begin
            return PC_LOAD;
        end else if (call) begin
            return PC_CALL;
        end else if (ret) begin
            return PC_RET;
        end else if (inc) begin
            return PC_INC;
        end
        return PC_HOLD;
    endfunction

endpackage

// File: rtl/pc_stack_if.sv
// Control/status bundle between the decoder and the PC sequencer.
//   master : drives the strobes (clr, load, call, ret, inc) and the target in
//   slave  : returns out, top, depth, empty, full, overflow, underflow
interface pc_stack_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned DepthW = $clog2(DEPTH + 1);

    logic              clr;
    logic              load;
    logic              call;
    logic              ret;
    logic              inc;
    logic [WIDTH-1:0]  in;
    logic [WIDTH-1:0]  out;
    logic [WIDTH-1:0]  top;
    logic [DepthW-1:0] depth;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;

    modport master (
        output clr, load, call, ret, inc, in,
        input  out, top, depth, empty, full, overflow, underflow
    );

    modport slave (
        input  clr, load, call, ret, inc, in,
        output out, top, depth, empty, full, overflow, underflow
    );

endinterface

// File: rtl/lifo_stack.sv
// Return-address LIFO storage.
//   clk, rst_n : clock, asynchronous active-low reset of the pointer only
//   clr        : synchronous empty
//   push/wdata : write a new top entry (ignored when full)
//   pop        : drop the top entry (ignored when empty)
//   rdata      : current top entry, 0 when empty
//   depth, full, empty : occupancy, all decoded from the pointer register
module lifo_stack #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned DepthW = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata,
    output logic [DepthW-1:0] depth,
    output logic              full,
    output logic              empty
);
    // At least one index bit even for a single-entry stack.
    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [DepthW-1:0] depth_q;
    logic [DepthW-1:0] depth_d;
    logic              do_push;
    logic              do_pop;
    logic [IdxW-1:0]   wr_idx;
    logic [IdxW-1:0]   rd_idx;

    assign full  = (depth_q == DepthW'(DEPTH));
    assign empty = (depth_q == '0);
    assign depth = depth_q;

    // Push wins over pop; the sequencer never asks for both at once.
    assign do_push = push & ~full & ~clr;
    assign do_pop  = pop & ~push & ~empty & ~clr;

    assign wr_idx = IdxW'(depth_q);
    assign rd_idx = IdxW'(depth_q - DepthW'(1));

    assign rdata = empty ? '0 : mem_q[rd_idx];

    always_comb begin
        depth_d = depth_q;
        if (clr) begin
            depth_d = '0;
        end else if (do_push) begin
            depth_d = depth_q + DepthW'(1);
        end else if (do_pop) begin
            depth_d = depth_q - DepthW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    // Entries at or above the pointer are don't-care, so storage has no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_idx] <= wdata;
        end
    end

endmodule

// File: rtl/pc_stack.sv
// Program counter with hardware call/return stack.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pc_stack_if slave; strobes clr/load/call/ret/inc and target in,
//                returns registered PC (out), top of stack, depth, empty, full
//                and the sticky overflow/underflow flags
module pc_stack
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned STEP      = 1,
    parameter int unsigned RESET_VEC = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    pc_stack_if.slave  bus
);
    localparam int unsigned    DepthW   = $clog2(DEPTH + 1);
    localparam logic [WIDTH-1:0] StepV  = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] ResetV = WIDTH'(RESET_VEC);

    pc_op_e            op;
    logic [WIDTH-1:0]  out_q;
    logic [WIDTH-1:0]  out_d;
    logic              ovf_q;
    logic              ovf_d;
    logic              unf_q;
    logic              unf_d;
    logic [WIDTH-1:0]  next_seq;
    logic [WIDTH-1:0]  stk_top;
    logic [DepthW-1:0] stk_depth;
    logic              stk_full;
    logic              stk_empty;

    assign op = pc_decode(bus.clr, bus.load, bus.call, bus.ret, bus.inc);

    // Shared by inc and the pushed return address; wraps modulo 2^WIDTH.
    assign next_seq = out_q + StepV;

    lifo_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (op == PC_CLR),
        .push  (op == PC_CALL),
        .pop   (op == PC_RET),
        .wdata (next_seq),
        .rdata (stk_top),
        .depth (stk_depth),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_comb begin
        out_d = out_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        unique case (op)
            PC_CLR: begin
                out_d = ResetV;
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end
            PC_LOAD: out_d = bus.in;
            PC_CALL: begin
                // Jump is taken even when the push is dropped.
                out_d = bus.in;
                if (stk_full) begin
                    ovf_d = 1'b1;
                end
            end
            PC_RET: begin
                if (stk_empty) begin
                    unf_d = 1'b1;
                end else begin
                    out_d = stk_top;
                end
            end
            PC_INC:  out_d = next_seq;
            default: out_d = out_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= ResetV;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            out_q <= out_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.top       = stk_top;
    assign bus.depth     = stk_depth;
    assign bus.empty     = stk_empty;
    assign bus.full      = stk_full;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;

endmodule

// File: tb/tb_pc_stack.sv
// Bench for pc_stack: two instances (16-bit/DEPTH 2/STEP 1/reset 0 and
// 8-bit/DEPTH 4/STEP 2/reset 0x30) checked every cycle against a queue-style
// model, plus literal expectations from the hand-worked scenarios.
module tb_pc_stack;

    logic clk;
    logic rst_n;
    bit   run;
    int   checks;
    int   errors;

    pc_stack_if #(.WIDTH(16), .DEPTH(2)) a_if ();
    pc_stack_if #(.WIDTH(8),  .DEPTH(4)) b_if ();

    pc_stack #(.WIDTH(16), .DEPTH(2), .STEP(1), .RESET_VEC(0)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if)
    );

    pc_stack #(.WIDTH(8), .DEPTH(4), .STEP(2), .RESET_VEC(32'h30)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    int m_pc  [2];
    int m_stk [2][8];
    int m_dep [2];
    bit m_ovf [2];
    bit m_unf [2];

    function automatic int c_mask(int k);  return (k == 0) ? 32'hFFFF : 32'hFF; endfunction
    function automatic int c_depth(int k); return (k == 0) ? 2 : 4;             endfunction
    function automatic int c_step(int k);  return (k == 0) ? 1 : 2;             endfunction
    function automatic int c_rv(int k);    return (k == 0) ? 0 : 32'h30;        endfunction

    task automatic model_reset(input int k);
        m_pc[k]  = c_rv(k);
        m_dep[k] = 0;
        m_ovf[k] = 1'b0;
        m_unf[k] = 1'b0;
    endtask

    task automatic model_step(input int k, input bit c, input bit l, input bit ca,
                              input bit r, input bit i, input int din);
        if (c) begin
            model_reset(k);
        end else if (l) begin
            m_pc[k] = din;
        end else if (ca) begin
            if (m_dep[k] == c_depth(k)) begin
                m_ovf[k] = 1'b1;
            end else begin
                m_stk[k][m_dep[k]] = (m_pc[k] + c_step(k)) & c_mask(k);
                m_dep[k] = m_dep[k] + 1;
            end
            m_pc[k] = din;
        end else if (r) begin
            if (m_dep[k] == 0) begin
                m_unf[k] = 1'b1;
            end else begin
                m_dep[k] = m_dep[k] - 1;
                m_pc[k]  = m_stk[k][m_dep[k]];
            end
        end else if (i) begin
            m_pc[k] = (m_pc[k] + c_step(k)) & c_mask(k);
        end
    endtask

    function automatic int m_top(int k);
        return (m_dep[k] == 0) ? 0 : m_stk[k][m_dep[k] - 1];
    endfunction

    initial begin
        model_reset(0);
        model_reset(1);
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset(0);
                model_reset(1);
            end else begin
                model_step(0, a_if.clr, a_if.load, a_if.call, a_if.ret, a_if.inc, int'(a_if.in));
                model_step(1, b_if.clr, b_if.load, b_if.call, b_if.ret, b_if.inc, int'(b_if.in));
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (run) begin
                chk("A.out",   int'(a_if.out),       m_pc[0]);
                chk("A.top",   int'(a_if.top),       m_top(0));
                chk("A.depth", int'(a_if.depth),     m_dep[0]);
                chk("A.empty", int'(a_if.empty),     int'(m_dep[0] == 0));
                chk("A.full",  int'(a_if.full),      int'(m_dep[0] == 2));
                chk("A.ovf",   int'(a_if.overflow),  int'(m_ovf[0]));
                chk("A.unf",   int'(a_if.underflow), int'(m_unf[0]));
                chk("B.out",   int'(b_if.out),       m_pc[1]);
                chk("B.top",   int'(b_if.top),       m_top(1));
                chk("B.depth", int'(b_if.depth),     m_dep[1]);
                chk("B.empty", int'(b_if.empty),     int'(m_dep[1] == 0));
                chk("B.full",  int'(b_if.full),      int'(m_dep[1] == 4));
                chk("B.ovf",   int'(b_if.overflow),  int'(m_ovf[1]));
                chk("B.unf",   int'(b_if.underflow), int'(m_unf[1]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_all();
        {a_if.clr, a_if.load, a_if.call, a_if.ret, a_if.inc} = 5'b0;
        {b_if.clr, b_if.load, b_if.call, b_if.ret, b_if.inc} = 5'b0;
        a_if.in = '0;
        b_if.in = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobe order: clr, load, call, ret, inc.
    task automatic drv_a(input logic [4:0] s, input logic [15:0] d);
        {a_if.clr, a_if.load, a_if.call, a_if.ret, a_if.inc} = s;
        a_if.in = d;
        tick();
        idle_all();
    endtask

    task automatic drv_b(input logic [4:0] s, input logic [7:0] d);
        {b_if.clr, b_if.load, b_if.call, b_if.ret, b_if.inc} = s;
        b_if.in = d;
        tick();
        idle_all();
    endtask

    localparam logic [4:0] S_CLR  = 5'b10000;
    localparam logic [4:0] S_LOAD = 5'b01000;
    localparam logic [4:0] S_CALL = 5'b00100;
    localparam logic [4:0] S_RET  = 5'b00010;
    localparam logic [4:0] S_INC  = 5'b00001;

    initial begin
        checks = 0;
        errors = 0;
        run    = 1'b0;
        rst_n  = 1'b0;
        idle_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        run = 1'b1;

        chk("lit A reset out", int'(a_if.out), 0);
        chk("lit B reset out", int'(b_if.out), 32'h30);
        chk("lit A reset empty", int'(a_if.empty), 1);

        // Increment from reset.
        drv_a(S_INC, 16'h0); chk("lit inc1", int'(a_if.out), 1);
        drv_a(S_INC, 16'h0); chk("lit inc2", int'(a_if.out), 2);
        drv_a(S_INC, 16'h0); chk("lit inc3", int'(a_if.out), 3);
        chk("lit inc depth", int'(a_if.depth), 0);

        // Call / inc / ret.
        drv_a(S_LOAD, 16'h0010);
        drv_a(S_CALL, 16'h0200); chk("lit call out", int'(a_if.out), 32'h200);
        chk("lit call depth", int'(a_if.depth), 1);
        chk("lit call top", int'(a_if.top), 32'h11);
        drv_a(S_INC, 16'h0);     chk("lit call inc", int'(a_if.out), 32'h201);
        drv_a(S_RET, 16'h0);     chk("lit ret out", int'(a_if.out), 32'h11);
        chk("lit ret depth", int'(a_if.depth), 0);

        // Overflow on a 2-deep stack.
        drv_a(S_LOAD, 16'h0005);
        drv_a(S_CALL, 16'h0100);
        drv_a(S_CALL, 16'h0200);
        drv_a(S_CALL, 16'h0300);
        chk("lit ovf out", int'(a_if.out), 32'h300);
        chk("lit ovf full", int'(a_if.full), 1);
        chk("lit ovf flag", int'(a_if.overflow), 1);
        chk("lit ovf top", int'(a_if.top), 32'h101);
        drv_a(S_RET, 16'h0);     chk("lit ovf ret1", int'(a_if.out), 32'h101);
        drv_a(S_RET, 16'h0);     chk("lit ovf ret2", int'(a_if.out), 32'h6);

        // Underflow, sticky across inc, cleared by clr.
        drv_a(S_LOAD, 16'h0040);
        drv_a(S_RET, 16'h0);
        chk("lit unf out", int'(a_if.out), 32'h40);
        chk("lit unf flag", int'(a_if.underflow), 1);
        drv_a(S_INC, 16'h0);
        chk("lit unf inc", int'(a_if.out), 32'h41);
        chk("lit unf sticky", int'(a_if.underflow), 1);
        drv_a(S_CLR, 16'h0);
        chk("lit clr out", int'(a_if.out), 0);
        chk("lit clr ovf", int'(a_if.overflow), 0);
        chk("lit clr unf", int'(a_if.underflow), 0);

        // Priority: load beats call/inc; clr beats load.
        drv_a(S_CALL, 16'h0050);
        drv_a(S_LOAD | S_CALL | S_INC, 16'h0123);
        chk("lit prio out", int'(a_if.out), 32'h123);
        chk("lit prio depth", int'(a_if.depth), 1);
        drv_a(S_CLR | S_LOAD, 16'h0077);
        chk("lit clr prio", int'(a_if.out), 0);

        // 16-bit wrap.
        drv_a(S_LOAD, 16'hFFFF);
        drv_a(S_INC, 16'h0);     chk("lit wrap16", int'(a_if.out), 0);

        // Instance B: ret beats inc on an empty stack.
        drv_b(S_RET | S_INC, 8'h0);
        chk("lit B ret+inc out", int'(b_if.out), 32'h30);
        chk("lit B unf", int'(b_if.underflow), 1);

        // 8-bit, STEP 2: return address wraps, back-to-back call/ret.
        drv_b(S_LOAD, 8'hFF);
        drv_b(S_CALL, 8'h10);
        chk("lit B call out", int'(b_if.out), 32'h10);
        chk("lit B call top", int'(b_if.top), 32'h01);
        drv_b(S_RET, 8'h0);
        chk("lit B ret out", int'(b_if.out), 32'h01);

        // Asynchronous reset mid-cycle, with a call strobe still held.
        drv_b(S_CALL, 8'h20);
        b_if.call = 1'b1;
        b_if.in   = 8'h44;
        #3 rst_n = 1'b0;
        #1;
        chk("lit arst B out",   int'(b_if.out), 32'h30);
        chk("lit arst B depth", int'(b_if.depth), 0);
        chk("lit arst B empty", int'(b_if.empty), 1);
        chk("lit arst B full",  int'(b_if.full), 0);
        chk("lit arst B top",   int'(b_if.top), 0);
        chk("lit arst B ovf",   int'(b_if.overflow), 0);
        chk("lit arst B unf",   int'(b_if.underflow), 0);
        chk("lit arst A out",   int'(a_if.out), 0);
        @(posedge clk);
        #1;
        chk("lit arst held", int'(b_if.out), 32'h30);
        idle_all();
        @(negedge clk);
        #1 rst_n = 1'b1;

        drv_b(S_INC, 8'h0);
        chk("lit B post-reset inc", int'(b_if.out), 32'h32);

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
